// File: rtl/hk_spi_responder.sv
// hk_spi_responder: SPI mode-0 responder for housekeeping register access.
// SCK/CSB/SDI are oversampled in the core clock domain; no SCK clock domain.
module hk_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  spi_sck,
  input  logic                  spi_csb,
  input  logic                  spi_sdi,
  output logic                  spi_sdo,
  output logic                  spi_sdo_oe,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_wen,
  output logic                  reg_ren,
  input  logic [7:0]            reg_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sck_q, csb_q, sdi_q;
  logic       sck_s, csb_s, sdi_s, sck_d;
  logic       rise, fall, shifting, byte_done;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] rx_byte, tx, addr_inc;
  logic       wr, rd, tx_fresh, sdo_q;
  logic       ren_pend, load_pend, inc_pend;

  // CSB synchronizer resets high so busy reads 0 in reset.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sck_q <= '0;
      csb_q <= '1;
      sdi_q <= '0;
      sck_d <= 1'b0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], spi_sck};
      csb_q <= {csb_q[SYNC_STAGES-2:0], spi_csb};
      sdi_q <= {sdi_q[SYNC_STAGES-2:0], spi_sdi};
      sck_d <= sck_s;
    end
  end

  assign sck_s     = sck_q[SYNC_STAGES-1];
  assign csb_s     = csb_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_q[SYNC_STAGES-1];
  assign rise      = sck_s & ~sck_d;
  assign fall      = ~sck_s & sck_d;
  assign shifting  = state inside {CMD, ADDR, DATA};
  assign byte_done = (bit_cnt == 3'd7);
  assign rx_byte   = {shift_in, sdi_s};
  assign addr_inc  = reg_addr[7:0] + 8'd1;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (csb_s) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:
          state_n = CMD;
        CMD:
          if (rise && byte_done)
            state_n = (rx_byte[7] | rx_byte[6]) ? ADDR : IGNORE;
        ADDR:
          if (rise && byte_done) state_n = DATA;
        DATA, IGNORE:
          state_n = state;
        default:
          state_n = IDLE;
      endcase
    end
  end

  // Strobe pipeline: write, then address bump, then read, then tx load.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      bit_cnt   <= '0;
      shift_in  <= '0;
      tx        <= '0;
      tx_fresh  <= 1'b0;
      sdo_q     <= 1'b0;
      wr        <= 1'b0;
      rd        <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wen   <= 1'b0;
      reg_ren   <= 1'b0;
      ren_pend  <= 1'b0;
      load_pend <= 1'b0;
      inc_pend  <= 1'b0;
    end else begin
      reg_wen   <= 1'b0;
      reg_ren   <= ren_pend;
      ren_pend  <= 1'b0;
      load_pend <= reg_ren;
      inc_pend  <= 1'b0;
      if (inc_pend) begin
        reg_addr <= ADDR_WIDTH'(addr_inc);
        ren_pend <= rd;
      end
      if (load_pend) begin
        tx       <= reg_rdata;
        tx_fresh <= 1'b1;
      end
      if (csb_s) begin
        bit_cnt   <= '0;
        wr        <= 1'b0;
        rd        <= 1'b0;
        sdo_q     <= 1'b0;
        tx_fresh  <= 1'b0;
        reg_ren   <= 1'b0;
        ren_pend  <= 1'b0;
        load_pend <= 1'b0;
        inc_pend  <= 1'b0;
      end else if (rise && shifting) begin
        shift_in <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_done) begin
          unique case (1'b1)
            state == CMD: begin
              wr <= rx_byte[7];
              rd <= rx_byte[6];
            end
            state == ADDR: begin
              reg_addr <= ADDR_WIDTH'(rx_byte);
              ren_pend <= rd;
            end
            state == DATA: begin
              if (wr) begin
                reg_wdata <= rx_byte;
                reg_wen   <= 1'b1;
              end
              inc_pend <= 1'b1;
            end
            default: ;
          endcase
        end
      end else if (fall && state == DATA && rd) begin
        if (tx_fresh) begin
          sdo_q    <= tx[7];
          tx_fresh <= 1'b0;
        end else begin
          sdo_q <= tx[6];
          tx    <= {tx[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_sdo    = sdo_q;
  assign spi_sdo_oe = (state == DATA) & rd & ~csb_s;
  assign busy       = ~csb_s;

endmodule

// File: tb/tb_hk_spi_responder.sv
// tb_hk_spi_responder: directed and random SPI transactions against
// a byte-level reference model of the housekeeping register space.
module tb_hk_spi_responder;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_csb = 1'b1;
  logic       spi_sdi = 1'b0;
  logic       spi_sdo, spi_sdo_oe, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_wen, reg_ren;
  logic [7:0] reg_rdata = 8'h00;

  hk_spi_responder #(
    .SYNC_STAGES(2),
    .ADDR_WIDTH (8)
  ) dut (
    .clock     (clock),
    .resetb    (resetb),
    .spi_sck   (spi_sck),
    .spi_csb   (spi_csb),
    .spi_sdi   (spi_sdi),
    .spi_sdo   (spi_sdo),
    .spi_sdo_oe(spi_sdo_oe),
    .busy      (busy),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wen   (reg_wen),
    .reg_ren   (reg_ren),
    .reg_rdata (reg_rdata)
  );

  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  int         both_err = 0;
  int         oe_rises;
  bit         oe_seen;
  logic [7:0] mem[256];
  logic [7:0] ref_mem[256];
  logic [15:0] wen_q[$];
  logic [7:0]  ren_q[$];
  logic [7:0]  data_q[$];
  logic [7:0]  miso_q[$];
  logic [7:0]  exp_addr;

  // Register-file peripheral: read data valid one clock after reg_ren.
  always @(posedge clock) begin
    if (reg_wen) begin
      mem[reg_addr] <= reg_wdata;
      wen_q.push_back({reg_addr, reg_wdata});
    end
    if (reg_ren) begin
      reg_rdata <= mem[reg_addr];
      ren_q.push_back(reg_addr);
    end
    if (reg_wen && reg_ren) both_err++;
    if (spi_sdo_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_xfer(input logic [7:0] v, input int nb,
                          output logic [7:0] m);
    m = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spi_sdi = v[7-i];
      wclk(8);
      spi_sck = 1'b1;
      m[7-i] = spi_sdo;
      if (spi_sdo_oe) oe_rises++;
      wclk(8);
      spi_sck = 1'b0;
    end
  endtask

  task automatic do_txn(input logic [7:0] cmd, input logic [7:0] addr);
    logic [7:0]  m, a;
    logic        wr, rd;
    logic [15:0] ew[$];
    logic [7:0]  er[$];
    logic [7:0]  em[$];
    wr = cmd[7];
    rd = cmd[6];
    a  = addr;
    if (wr || rd) begin
      foreach (data_q[i]) begin
        if (rd) begin
          er.push_back(a);
          em.push_back(ref_mem[a]);
        end
        if (wr) begin
          ew.push_back({a, data_q[i]});
          ref_mem[a] = data_q[i];
        end
        a = a + 8'd1;
      end
      if (rd) er.push_back(a);
      exp_addr = a;
    end
    wen_q.delete();
    ren_q.delete();
    miso_q.delete();
    oe_seen  = 1'b0;
    oe_rises = 0;
    spi_csb = 1'b0;
    wclk(4);
    spi_xfer(cmd, 8, m);
    spi_xfer(addr, 8, m);
    foreach (data_q[i]) begin
      spi_xfer(data_q[i], 8, m);
      miso_q.push_back(m);
    end
    wclk(4);
    spi_csb = 1'b1;
    wclk(6);
    check("wen_count", wen_q.size(), ew.size());
    for (int i = 0; i < ew.size(); i++)
      check("wen_entry", (i < wen_q.size()) ? 32'(wen_q[i]) : 32'hDEAD_BEEF,
            32'(ew[i]));
    check("ren_count", ren_q.size(), er.size());
    for (int i = 0; i < er.size(); i++)
      check("ren_addr", (i < ren_q.size()) ? 32'(ren_q[i]) : 32'hDEAD_BEEF,
            32'(er[i]));
    if (rd)
      foreach (em[i]) check("sdo_byte", miso_q[i], em[i]);
    check("oe_rises", oe_rises, rd ? 8 * data_q.size() : 0);
    if (!rd) check("oe_seen", oe_seen, 1'b0);
    check("oe_idle", spi_sdo_oe, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("reg_addr", reg_addr, exp_addr);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] m, cmd, low;
    int diffs;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'hFF;
      ref_mem[i] = 8'(i) ^ 8'hFF;
    end
    exp_addr = 8'h00;
    wclk(3);
    check("reset_outs", {spi_sdo, spi_sdo_oe, busy, reg_wen, reg_ren,
                         reg_addr, reg_wdata}, 32'h0);
    resetb = 1'b1;
    wclk(4);

    data_q = '{8'hA5, 8'h3C};
    do_txn(8'h80, 8'h10);
    check("wr_mem10", mem[8'h10], 8'hA5);
    check("wr_mem11", mem[8'h11], 8'h3C);

    data_q = '{8'h00, 8'h00};
    do_txn(8'h40, 8'h20);
    check("rd_byte0", miso_q[0], 8'hDF);
    check("rd_byte1", miso_q[1], 8'hDE);
    check("rd_prefetch", (ren_q.size() == 3) ? ren_q[2] : 8'h00, 8'h22);

    mem[8'hFF] = 8'h11; ref_mem[8'hFF] = 8'h11;
    mem[8'h00] = 8'h22; ref_mem[8'h00] = 8'h22;
    data_q = '{8'h77, 8'h88};
    do_txn(8'hC0, 8'hFF);
    check("rw_sdo0", miso_q[0], 8'h11);
    check("rw_sdo1", miso_q[1], 8'h22);
    check("rw_memFF", mem[8'hFF], 8'h77);
    check("rw_mem00", mem[8'h00], 8'h88);
    check("rw_wrap", reg_addr, 8'h01);

    wen_q.delete();
    oe_seen = 1'b0;
    spi_csb = 1'b0;
    wclk(4);
    spi_xfer(8'h80, 8, m);
    spi_xfer(8'h33, 8, m);
    spi_xfer(8'hFF, 5, m);
    wclk(4);
    spi_csb = 1'b1;
    wclk(6);
    check("abort_wen", wen_q.size(), 0);
    check("abort_oe", oe_seen, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_addr", reg_addr, 8'h33);
    exp_addr = 8'h33;

    data_q = '{8'hAA};
    do_txn(8'h00, 8'h12);

    spi_csb = 1'b0;
    wclk(4);
    spi_xfer(8'h40, 8, m);
    spi_xfer(8'h30, 8, m);
    spi_xfer(8'h00, 3, m);
    check("rst_oe_pre", spi_sdo_oe, 1'b1);
    resetb = 1'b0;
    #1;
    check("rst_outs", {spi_sdo, spi_sdo_oe, busy, reg_wen, reg_ren,
                       reg_addr, reg_wdata}, 32'h0);
    wclk(2);
    spi_csb = 1'b1;
    spi_sck = 1'b0;
    wclk(2);
    resetb = 1'b1;
    wclk(4);
    exp_addr = 8'h00;
    data_q = '{8'h5A};
    do_txn(8'h80, 8'h05);
    check("rst_after_mem", mem[8'h05], 8'h5A);

    for (int t = 0; t < 200; t++) begin
      low = 8'($urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0:       cmd = 8'h80 | low;
        1:       cmd = 8'h40 | low;
        2:       cmd = 8'hC0 | low;
        default: cmd = low;
      endcase
      data_q = '{8'($urandom)};
      do_txn(cmd, 8'($urandom));
    end

    diffs = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_final", diffs, 0);
    check("wen_ren_overlap", both_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
